// File: rtl/detect_window_monitor.sv
// detect_window_monitor: hit-density monitor for the serial cycle detector.
// Counts hits, opens a WINDOW-clock window on the first hit, raises a held
// alarm once THRESH hits land in one window and drops it after QUIET
// hit-free clocks. Optional hit-spacing measurement is built only when
// DETWIN_GAP_EN is defined; otherwise gap/gap_valid are tied to 0.
module detect_window_monitor #(
    parameter int WINDOW = 16,
    parameter int THRESH = 3,
    parameter int QUIET  = 8,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             r,
    input  logic             hit,
    input  logic             clr,
    output logic             alarm,
    output logic [7:0]       win_cnt,
    output logic [CNT_W-1:0] total_cnt,
    output logic [CNT_W-1:0] gap,
    output logic             gap_valid
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        ALARM = 2'd2
    } state_t;

    localparam logic [7:0]       WIN_LOAD   = 8'(WINDOW - 1);
    localparam logic [7:0]       QUIET_LOAD = 8'(QUIET);
    localparam logic [7:0]       THRESH_V   = 8'(THRESH);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    state_t           state_q;
    logic             alarm_q;
    logic [7:0]       win_cnt_q;
    logic [7:0]       timer_q;
    logic [CNT_W-1:0] total_cnt_q;

    // Window/alarm FSM plus hit counters; r beats clr beats normal operation.
    // NOTE: all state here uses non-blocking assignments so every branch reads
    // the pre-edge values, matching the one-clock latency of the outputs.
    always_ff @(posedge clk) begin
        if (!r) begin
            state_q     <= IDLE;
            alarm_q     <= 1'b0;
            win_cnt_q   <= 8'd0;
            timer_q     <= 8'd0;
            total_cnt_q <= '0;
        end else if (clr) begin
            state_q     <= IDLE;
            alarm_q     <= 1'b0;
            win_cnt_q   <= 8'd0;
            timer_q     <= 8'd0;
            total_cnt_q <= '0;
        end else begin
            if (hit && total_cnt_q != CNT_MAX) begin
                total_cnt_q <= total_cnt_q + 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (hit) begin
                        win_cnt_q <= 8'd1;
                        if (THRESH == 1) begin
                            state_q <= ALARM;
                            alarm_q <= 1'b1;
                            timer_q <= QUIET_LOAD;
                        end else begin
                            state_q <= ARMED;
                            timer_q <= WIN_LOAD;
                        end
                    end
                end
                ARMED: begin
                    if (hit && (win_cnt_q + 8'd1) == THRESH_V) begin
                        // Threshold reached: takes priority over window expiry.
                        state_q   <= ALARM;
                        alarm_q   <= 1'b1;
                        win_cnt_q <= win_cnt_q + 8'd1;
                        timer_q   <= QUIET_LOAD;
                    end else if (timer_q == 8'd1) begin
                        if (hit) begin
                            // The hit on the closing edge opens a fresh window.
                            win_cnt_q <= 8'd1;
                            timer_q   <= WIN_LOAD;
                        end else begin
                            state_q   <= IDLE;
                            win_cnt_q <= 8'd0;
                            timer_q   <= 8'd0;
                        end
                    end else begin
                        timer_q <= timer_q - 8'd1;
                        if (hit) begin
                            win_cnt_q <= win_cnt_q + 8'd1;
                        end
                    end
                end
                ALARM: begin
                    if (hit) begin
                        timer_q <= QUIET_LOAD;
                    end else if (timer_q == 8'd1) begin
                        state_q   <= IDLE;
                        alarm_q   <= 1'b0;
                        win_cnt_q <= 8'd0;
                        timer_q   <= 8'd0;
                    end else begin
                        timer_q <= timer_q - 8'd1;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    alarm_q   <= 1'b0;
                    win_cnt_q <= 8'd0;
                    timer_q   <= 8'd0;
                end
            endcase
        end
    end

    assign alarm     = alarm_q;
    assign win_cnt   = win_cnt_q;
    assign total_cnt = total_cnt_q;

`ifdef DETWIN_GAP_EN
    logic             hit_ok;
    logic [CNT_W-1:0] gap_cnt_d,   gap_cnt_q;
    logic             first_d,     first_q;
    logic [CNT_W-1:0] gap_d,       gap_q;
    logic             gap_valid_d, gap_valid_q;

    // A hit in a clr cycle is dropped; clr itself never resets the gap logic.
    assign hit_ok = hit & ~clr;

    // Next-state of the hit-spacing counter and its saturating gap capture.
    // NOTE: every _d gets a default first so no latch is inferred.
    always_comb begin
        gap_cnt_d   = (gap_cnt_q == CNT_MAX) ? gap_cnt_q : gap_cnt_q + 1'b1;
        first_d     = first_q;
        gap_d       = gap_q;
        gap_valid_d = 1'b0;
        if (hit_ok) begin
            if (first_q) begin
                gap_d       = (gap_cnt_q == CNT_MAX) ? CNT_MAX : gap_cnt_q + 1'b1;
                gap_valid_d = 1'b1;
            end
            gap_cnt_d = '0;
            first_d   = 1'b1;
        end
    end

    // Gap registers; only reset clears them.
    always_ff @(posedge clk) begin
        if (!r) begin
            gap_cnt_q   <= '0;
            first_q     <= 1'b0;
            gap_q       <= '0;
            gap_valid_q <= 1'b0;
        end else begin
            gap_cnt_q   <= gap_cnt_d;
            first_q     <= first_d;
            gap_q       <= gap_d;
            gap_valid_q <= gap_valid_d;
        end
    end

    assign gap       = gap_q;
    assign gap_valid = gap_valid_q;
`else
    assign gap       = '0;
    assign gap_valid = 1'b0;
`endif

endmodule

// File: tb/tb_detect_window_monitor.sv
// Directed testbench for detect_window_monitor (WINDOW=16, THRESH=3, QUIET=8).
// A second instance with CNT_W=4 covers total_cnt saturation.
// Edge numbering: edge 0 is the reset edge, edges 1.. follow.
module tb_detect_window_monitor;

    logic       clk = 1'b0;
    logic       r = 1'b0;
    logic       hit = 1'b0;
    logic       clr = 1'b0;
    logic       alarm,  alarm4;
    logic [7:0] win_cnt, win_cnt4;
    logic [7:0] total_cnt, gap;
    logic [3:0] total_cnt4, gap4;
    logic       gap_valid, gap_valid4;

    int n_checks = 0;
    int n_errors = 0;

    detect_window_monitor #(.WINDOW(16), .THRESH(3), .QUIET(8), .CNT_W(8)) dut (
        .clk(clk), .r(r), .hit(hit), .clr(clr),
        .alarm(alarm), .win_cnt(win_cnt), .total_cnt(total_cnt),
        .gap(gap), .gap_valid(gap_valid)
    );

    detect_window_monitor #(.WINDOW(16), .THRESH(3), .QUIET(8), .CNT_W(4)) dut4 (
        .clk(clk), .r(r), .hit(hit), .clr(clr),
        .alarm(alarm4), .win_cnt(win_cnt4), .total_cnt(total_cnt4),
        .gap(gap4), .gap_valid(gap_valid4)
    );

    always #5 clk = ~clk;

    // One clock edge with the given inputs; outputs sampled 1 ns after it.
    task automatic step(input logic h, input logic c);
        hit = h;
        clr = c;
        @(posedge clk);
        #1;
        hit = 1'b0;
        clr = 1'b0;
    endtask

    task automatic do_reset();
        r = 1'b0;
        step(1'b0, 1'b0);
        r = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (alarm !== 1'b0 || win_cnt !== 8'd0 || total_cnt !== 8'd0 ||
            gap !== 8'd0 || gap_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_state: alarm=%b win=%0d total=%0d gap=%0d gv=%b, want all 0",
                     alarm, win_cnt, total_cnt, gap, gap_valid);
        end
    endtask

    // Hits at edges 2, 5, 9 -> win_cnt 1, 2, 3 and alarm after edge 9.
    task automatic test_threshold();
        do_reset();
        for (int e = 1; e <= 9; e++) begin
            step(e == 2 || e == 5 || e == 9, 1'b0);
            if (e == 2 || e == 5) begin
                n_checks++;
                if (win_cnt !== ((e == 2) ? 8'd1 : 8'd2)) begin
                    n_errors++;
                    $display("FAIL thr_win_e%0d: got %0d want %0d", e, win_cnt, (e == 2) ? 1 : 2);
                end
            end
            if (e == 8) begin
                n_checks++;
                if (alarm !== 1'b0) begin
                    n_errors++;
                    $display("FAIL thr_alarm_early: got %b want 0", alarm);
                end
            end
        end
        n_checks++;
        if (alarm !== 1'b1 || win_cnt !== 8'd3 || total_cnt !== 8'd3) begin
            n_errors++;
            $display("FAIL thr_hit3: alarm=%b win=%0d total=%0d, want 1/3/3", alarm, win_cnt, total_cnt);
        end
    endtask

    // Hits at 2 and 5 only: ARMED through edge 16, IDLE after edge 17.
    task automatic test_window_expiry();
        int alarm_seen;
        alarm_seen = 0;
        do_reset();
        for (int e = 1; e <= 18; e++) begin
            step(e == 2 || e == 5, 1'b0);
            if (alarm !== 1'b0) alarm_seen++;
            if (e == 16) begin
                n_checks++;
                if (win_cnt !== 8'd2) begin
                    n_errors++;
                    $display("FAIL win_e16: got %0d want 2", win_cnt);
                end
            end
            if (e == 17) begin
                n_checks++;
                if (win_cnt !== 8'd0) begin
                    n_errors++;
                    $display("FAIL win_e17: got %0d want 0", win_cnt);
                end
            end
        end
        n_checks++;
        if (alarm_seen != 0) begin
            n_errors++;
            $display("FAIL win_no_alarm: alarm high on %0d edges, want 0", alarm_seen);
        end
        // The window has closed, so a new hit restarts win_cnt at 1.
        step(1'b1, 1'b0);
        n_checks++;
        if (win_cnt !== 8'd1 || total_cnt !== 8'd3) begin
            n_errors++;
            $display("FAIL win_reopen: win=%0d total=%0d, want 1/3", win_cnt, total_cnt);
        end
    endtask

    // Alarm at 9 falls after 17; an extra hit at 12 moves the fall to after 20.
    task automatic test_quiet();
        do_reset();
        for (int e = 1; e <= 18; e++) begin
            step(e == 2 || e == 5 || e == 9, 1'b0);
            if (e == 16 || e == 17) begin
                n_checks++;
                if (alarm !== (e == 16)) begin
                    n_errors++;
                    $display("FAIL quiet_e%0d: alarm=%b want %b", e, alarm, e == 16);
                end
            end
            if (e == 17) begin
                n_checks++;
                if (win_cnt !== 8'd0) begin
                    n_errors++;
                    $display("FAIL quiet_win_clear: got %0d want 0", win_cnt);
                end
            end
        end
        do_reset();
        for (int e = 1; e <= 21; e++) begin
            step(e == 2 || e == 5 || e == 9 || e == 12, 1'b0);
            if (e == 12) begin
                n_checks++;
                if (win_cnt !== 8'd3 || total_cnt !== 8'd4) begin
                    n_errors++;
                    $display("FAIL quiet_frozen: win=%0d total=%0d, want 3/4", win_cnt, total_cnt);
                end
            end
            if (e == 17 || e == 19 || e == 20) begin
                n_checks++;
                if (alarm !== (e != 20)) begin
                    n_errors++;
                    $display("FAIL quiet_ext_e%0d: alarm=%b want %b", e, alarm, e != 20);
                end
            end
        end
    endtask

    // Hits at 3, 4, 10: gap=1 after 4, gap=6 after 10 (zero without the macro).
    task automatic test_gap();
        do_reset();
        for (int e = 1; e <= 11; e++) begin
            step(e == 3 || e == 4 || e == 10, 1'b0);
`ifdef DETWIN_GAP_EN
            if (e == 3 || e == 5 || e == 9 || e == 11) begin
                n_checks++;
                if (gap_valid !== 1'b0) begin
                    n_errors++;
                    $display("FAIL gap_valid_idle_e%0d: got %b want 0", e, gap_valid);
                end
            end
            if (e == 4 || e == 10) begin
                n_checks++;
                if (gap_valid !== 1'b1 || gap !== ((e == 4) ? 8'd1 : 8'd6)) begin
                    n_errors++;
                    $display("FAIL gap_e%0d: gv=%b gap=%0d, want 1/%0d", e, gap_valid, gap,
                             (e == 4) ? 1 : 6);
                end
            end
            if (e == 9) begin
                n_checks++;
                if (gap !== 8'd1) begin
                    n_errors++;
                    $display("FAIL gap_hold: got %0d want 1", gap);
                end
            end
`else
            n_checks++;
            if (gap !== 8'd0 || gap_valid !== 1'b0) begin
                n_errors++;
                $display("FAIL gap_off_e%0d: gap=%0d gv=%b, want 0/0", e, gap, gap_valid);
            end
`endif
        end
    endtask

    // clr together with hit while in ALARM: back to IDLE, the hit is dropped.
    task automatic test_clr_in_alarm();
        do_reset();
        for (int e = 1; e <= 9; e++) step(e == 2 || e == 5 || e == 9, 1'b0);
        step(1'b1, 1'b1);
        n_checks++;
        if (alarm !== 1'b0 || win_cnt !== 8'd0 || total_cnt !== 8'd0) begin
            n_errors++;
            $display("FAIL clr_alarm: alarm=%b win=%0d total=%0d, want 0/0/0", alarm, win_cnt, total_cnt);
        end
        step(1'b1, 1'b0);
        n_checks++;
        if (alarm !== 1'b0 || win_cnt !== 8'd1 || total_cnt !== 8'd1) begin
            n_errors++;
            $display("FAIL clr_then_hit: alarm=%b win=%0d total=%0d, want 0/1/1", alarm, win_cnt, total_cnt);
        end
    endtask

    // Window re-opened by a hit on its closing edge, then back-to-back hits.
    task automatic test_back_to_back();
        do_reset();
        for (int e = 1; e <= 17; e++) step(e == 2 || e == 17, 1'b0);
        n_checks++;
        if (win_cnt !== 8'd1 || alarm !== 1'b0) begin
            n_errors++;
            $display("FAIL b2b_reopen: win=%0d alarm=%b, want 1/0", win_cnt, alarm);
        end
        step(1'b1, 1'b0);
        n_checks++;
        if (win_cnt !== 8'd2 || alarm !== 1'b0) begin
            n_errors++;
            $display("FAIL b2b_second: win=%0d alarm=%b, want 2/0", win_cnt, alarm);
        end
        step(1'b1, 1'b0);
        n_checks++;
        if (win_cnt !== 8'd3 || alarm !== 1'b1 || total_cnt !== 8'd4) begin
            n_errors++;
            $display("FAIL b2b_third: win=%0d alarm=%b total=%0d, want 3/1/4", win_cnt, alarm, total_cnt);
        end
    endtask

    // 20 consecutive hits: CNT_W=4 saturates at 15; reset mid-stream clears all.
    task automatic test_saturation();
        do_reset();
        for (int i = 1; i <= 20; i++) begin
            step(1'b1, 1'b0);
            if (i == 14 || i == 15 || i == 20) begin
                n_checks++;
                if (total_cnt4 !== ((i == 14) ? 4'd14 : 4'd15)) begin
                    n_errors++;
                    $display("FAIL sat4_i%0d: got %0d want %0d", i, total_cnt4, (i == 14) ? 14 : 15);
                end
            end
        end
        n_checks++;
        if (total_cnt !== 8'd20) begin
            n_errors++;
            $display("FAIL sat8_total: got %0d want 20", total_cnt);
        end
`ifdef DETWIN_GAP_EN
        n_checks++;
        if (gap4 !== 4'd1 || gap_valid4 !== 1'b1) begin
            n_errors++;
            $display("FAIL sat_gap_b2b: gap=%0d gv=%b, want 1/1", gap4, gap_valid4);
        end
`endif
        r = 1'b0;
        step(1'b1, 1'b0);
        r = 1'b1;
        n_checks++;
        if (alarm !== 1'b0 || win_cnt !== 8'd0 || total_cnt !== 8'd0 || gap !== 8'd0 ||
            gap_valid !== 1'b0 || alarm4 !== 1'b0 || win_cnt4 !== 8'd0 ||
            total_cnt4 !== 4'd0 || gap4 !== 4'd0 || gap_valid4 !== 1'b0) begin
            n_errors++;
            $display("FAIL sat_reset: alarm=%b win=%0d total=%0d total4=%0d gap=%0d gap4=%0d, want all 0",
                     alarm, win_cnt, total_cnt, total_cnt4, gap, gap4);
        end
    endtask

    initial begin
        test_reset();
        test_threshold();
        test_window_expiry();
        test_quiet();
        test_gap();
        test_clr_in_alarm();
        test_back_to_back();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/detect_window_monitor.md
# detect_window_monitor

Downstream consumer of the serial cycle detector's one-cycle `out` hit pulses. Counts hits, checks hit density over a fixed window that opens on the first hit, raises a held alarm when the threshold is reached, and optionally measures the spacing between consecutive hits. All outputs are registered, for status readout and interrupt generation.

## Interface
- `WINDOW`, 16: window length in clocks, counted from the hit that opens it; legal range 2..255.
- `THRESH`, 3: hits within one window that trigger the alarm; legal range 1..255.
- `QUIET`, 8: consecutive hit-free clocks required to leave alarm; legal range 1..255.
- `CNT_W`, 8: width of the `total_cnt` and `gap` outputs; minimum 4.
- `clk` in 1: single clock; everything updates on the rising edge.
- `r` in 1: reset. One clock, synchronous, active-low.
- `hit` in 1: detector output, sampled every edge. Back-to-back highs count as separate hits.
- `clr` in 1: synchronous clear of FSM, counters, and alarm. Does not clear `gap` or `gap_valid`.
- `alarm` out 1: high while the FSM is in ALARM.
- `win_cnt` out 8: hits in the current window. Holds its value while in ALARM.
- `total_cnt` out CNT_W: hits since reset or `clr`. Saturates at all-ones.
- `gap` out CNT_W: clocks between the last two hits. Saturates at all-ones.
- `gap_valid` out 1: one-clock pulse when `gap` updates.

## Operation
- Reset (`r`=0 at an edge): state IDLE, `alarm`=0, `win_cnt`=0, `total_cnt`=0, `gap`=0, `gap_valid`=0, internal timer=0, gap counter=0, first-hit flag=0.
- Priority at an edge: `r` low, then `clr` high, then normal operation. A hit in a `clr` cycle is dropped.
- `clr`: return to IDLE, `alarm`=0, `win_cnt`=0, `total_cnt`=0.
- On every counted hit, `total_cnt` increments unless it is already all-ones.

FSM states and transitions:
- IDLE
  - `hit` with THRESH=1: go to ALARM, `win_cnt`=1, quiet timer=QUIET.
  - `hit` otherwise: go to ARMED, `win_cnt`=1, window timer=WINDOW-1.
- ARMED
  - Each clock: the timer decrements; a `hit` increments `win_cnt`.
  - If `win_cnt` after increment equals THRESH: go to ALARM, quiet timer=QUIET. This check wins over expiry.
  - Else, if timer==1 at the edge (window ends): with `hit` low, go to IDLE with `win_cnt`=0; with `hit` high, that hit opens a new window: stay ARMED, `win_cnt`=1, timer=WINDOW-1.
- ALARM
  - `alarm`=1 and `win_cnt` frozen.
  - `hit` reloads the quiet timer to QUIET. Hits still count in `total_cnt` and gap logic.
  - Otherwise the timer decrements; at timer==1 go to IDLE, with `alarm`=0 and `win_cnt`=0 on that same edge.

Gap logic:
- A gap counter increments each clock, saturating at all-ones.
- On a hit: if the first-hit flag is set, `gap` is loaded with the counter value plus 1 (saturating) and `gap_valid`=1 for one clock. Then the counter is reset to 0 and the flag is set.
- Hits on consecutive clocks give `gap`=1.
- `clr` leaves `gap`, `gap_valid`, the counter and the flag untouched.

## Timing
- Latency is one clock. A hit sampled at edge N is reflected in `win_cnt`, `total_cnt`, `alarm`, `gap` and `gap_valid` immediately after edge N.
- No combinational path from any input to any output.
- A window spans exactly WINDOW edges, counting the edge of the opening hit.
- ALARM exit occurs exactly QUIET edges after the last hit.
- Reset asserted mid-window or mid-alarm takes effect at that edge. No partial state survives.

## Configuration
- `DETWIN_GAP_EN` defined: gap counter, first-hit flag, `gap` and `gap_valid` are built as described.
- Not defined: this logic is removed, `gap` is tied to 0 and `gap_valid` to 0. All other behaviour is identical.

## Test plan
- Reset, then hits at edges 2, 5, 9 (WINDOW=16, THRESH=3) -> `win_cnt` steps 1, 2, 3; `alarm` rises after edge 9; `total_cnt`=3.
- Two hits at edges 2 and 5, then none -> ARMED until edge 17; after edge 17 back to IDLE with `win_cnt`=0 and `alarm` never high.
- Alarm entered at edge 9, then no hits (QUIET=8) -> `alarm` falls after edge 17. A repeat run with an extra hit at edge 12 delays the fall to after edge 20.
- Hits at edges 3 and 4, then at 10 (`DETWIN_GAP_EN` defined) -> `gap_valid` pulses after edge 4 with `gap`=1 and after edge 10 with `gap`=6; a build without the macro shows `gap`=0 and `gap_valid`=0 throughout.
- `clr`=1 and `hit`=1 on the same edge while in ALARM -> IDLE, `alarm`=0, `total_cnt`=0; the hit is not counted.
- CNT_W=4 with 20 hits -> `total_cnt` saturates at 15; `r`=0 mid-stream -> all outputs read 0 after that edge.
